me_comp_residual: RTL and testbench

Motion-compensation residual stage placed directly downstream of the 4x4-in-8x8 motion estimator. It snoops the same pixel stream the estimator consumes (16 current-block pixels, then 64 search-area pixels), buffers both, then accepts the estimator's two-cycle vector output (x, then y). It emits the 16 signed residuals current minus displaced reference in raster order for the entropy/quantiser stage.

---
 rtl/me_comp_residual.sv | 132 +++++++++++++
 tb/tb_me_comp_residual.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/me_comp_residual.sv
// Motion-compensation residual stage: buffers a 4x4 block and 8x8 search area, then emits
// the 16 signed residuals (current minus displaced reference) for a two-cycle vector.
module me_comp_residual (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       block_valid,
    input  logic       area_valid,
    input  logic [7:0] in_data,
    input  logic       vec_valid,
    input  logic [2:0] vec_in,
    output logic       out_valid,
    output logic [8:0] out_residual
);

    typedef enum logic [1:0] {StLoad, StWaitVx, StWaitVy, StOut} state_t;

    state_t     state_q, state_d;
    logic [3:0] bc_q, bc_d;
    logic [5:0] ac_q, ac_d;
    logic [3:0] oc_q, oc_d;
    logic [2:0] vx_q, vx_d;
    logic [2:0] vy_q, vy_d;
    logic       out_valid_d;
    logic [8:0] out_residual_d;

    logic [7:0] blk_mem  [16];
    logic [7:0] area_mem [64];

    logic       blk_we, area_we;
    logic [2:0] ref_row, ref_col;
    logic [7:0] ref_pix;
    logic [8:0] residual;

    // Out-of-range components saturate to the +/-2 search window.
    function automatic logic [2:0] clamp3(input logic [2:0] v);
        logic [2:0] r;
        case (v)
            3'b100, 3'b101: r = 3'b110;
            3'b011:         r = 3'b010;
            default:        r = v;
        endcase
        return r;
    endfunction

    assign blk_we  = (state_q == StLoad) && block_valid;
    assign area_we = (state_q == StLoad) && !block_valid && area_valid;

    always_ff @(posedge clk) begin
        if (blk_we) begin
            blk_mem[bc_q] <= in_data;
        end
        if (area_we) begin
            area_mem[ac_q] <= in_data;
        end
    end

    // Offsets stay within 0..7, so 3-bit modular arithmetic is exact.
    assign ref_row  = 3'd2 - vy_q + {1'b0, oc_q[3:2]};
    assign ref_col  = 3'd2 + vx_q + {1'b0, oc_q[1:0]};
    assign ref_pix  = area_mem[{ref_row, ref_col}];
    assign residual = {1'b0, blk_mem[oc_q]} - {1'b0, ref_pix};

    always_comb begin
        state_d        = state_q;
        bc_d           = bc_q;
        ac_d           = ac_q;
        oc_d           = oc_q;
        vx_d           = vx_q;
        vy_d           = vy_q;
        out_valid_d    = 1'b0;
        out_residual_d = 9'd0;
        unique case (state_q)
            StLoad: begin
                if (block_valid) begin
                    bc_d = bc_q + 4'd1;
                end else if (area_valid) begin
                    if (ac_q == 6'd63) begin
                        ac_d    = 6'd0;
                        bc_d    = 4'd0;
                        state_d = StWaitVx;
                    end else begin
                        ac_d = ac_q + 6'd1;
                    end
                end
            end
            StWaitVx: begin
                if (vec_valid) begin
                    vx_d    = clamp3(vec_in);
                    state_d = StWaitVy;
                end
            end
            StWaitVy: begin
                if (vec_valid) begin
                    vy_d    = clamp3(vec_in);
                    state_d = StOut;
                end
            end
            StOut: begin
                out_valid_d    = 1'b1;
                out_residual_d = residual;
                oc_d           = oc_q + 4'd1;
                if (oc_q == 4'd15) begin
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StLoad;
            bc_q         <= 4'd0;
            ac_q         <= 6'd0;
            oc_q         <= 4'd0;
            vx_q         <= 3'd0;
            vy_q         <= 3'd0;
            out_valid    <= 1'b0;
            out_residual <= 9'd0;
        end else begin
            state_q      <= state_d;
            bc_q         <= bc_d;
            ac_q         <= ac_d;
            oc_q         <= oc_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            out_valid    <= out_valid_d;
            out_residual <= out_residual_d;
        end
    end

endmodule

// File: tb/tb_me_comp_residual.sv
// Scoreboard bench for me_comp_residual: a frame-level model predicts residuals into a queue
// that an independent monitor drains whenever out_valid is high.
module tb_me_comp_residual;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       block_valid = 1'b0;
    logic       area_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       vec_valid = 1'b0;
    logic [2:0] vec_in = 3'd0;
    logic       out_valid;
    logic [8:0] out_residual;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    bit check_fall = 1'b0;

    // Reference model of what the DUT buffers should hold.
    int m_blk[16];
    int m_area[64];
    int m_bc = 0;
    int m_ac = 0;
    int src_b[16];
    int src_a[64];

    me_comp_residual dut (
        .clk(clk),
        .rst_n(rst_n),
        .block_valid(block_valid),
        .area_valid(area_valid),
        .in_data(in_data),
        .vec_valid(vec_valid),
        .vec_in(vec_in),
        .out_valid(out_valid),
        .out_residual(out_residual)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    chk("residual", int'($signed(out_residual)), exp_q.pop_front());
                end
            end else begin
                chk("idle_zero", int'(out_residual), 0);
            end
        end
    end

    task automatic fall_check();
        if (check_fall) begin
            chk("valid_fall", int'(out_valid), 0);
            check_fall = 1'b0;
        end
    endtask

    task automatic push_block(input int p);
        @(negedge clk);
        block_valid = 1'b1;
        in_data = 8'(p);
        @(posedge clk);
        #1;
        block_valid = 1'b0;
        fall_check();
        m_blk[m_bc] = p;
        m_bc = (m_bc + 1) % 16;
    endtask

    task automatic model_area(input int p);
        m_area[m_ac] = p;
        if (m_ac == 63) begin
            m_ac = 0;
            m_bc = 0;
        end else begin
            m_ac++;
        end
    endtask

    task automatic push_area(input int p);
        @(negedge clk);
        area_valid = 1'b1;
        in_data = 8'(p);
        @(posedge clk);
        #1;
        area_valid = 1'b0;
        model_area(p);
    endtask

    // Both strobes high: only the block pixel may land.
    task automatic push_both(input int p);
        @(negedge clk);
        block_valid = 1'b1;
        area_valid = 1'b1;
        in_data = 8'(p);
        @(posedge clk);
        #1;
        block_valid = 1'b0;
        area_valid = 1'b0;
        m_blk[m_bc] = p;
        m_bc = (m_bc + 1) % 16;
    endtask

    function automatic int clampv(input logic [2:0] raw);
        int v;
        v = $signed(raw);
        if (v < -2) return -2;
        if (v > 2) return 2;
        return v;
    endfunction

    task automatic load_frame();
        for (int i = 0; i < 16; i++) push_block(src_b[i]);
        for (int i = 0; i < 64; i++) push_area(src_a[i]);
    endtask

    // abort_at > 0 pulses reset just after that many residuals have been registered.
    task automatic send_vec(input logic [2:0] x, input logic [2:0] y, input int abort_at);
        int vx, vy;
        vx = clampv(x);
        vy = clampv(y);
        @(negedge clk);
        vec_valid = 1'b1;
        vec_in = x;
        @(negedge clk);
        vec_in = y;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back(m_blk[r*4 + c] - m_area[(2 - vy + r)*8 + 2 + vx + c]);
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        vec_in = 3'd0;
        chk("valid_pre", int'(out_valid), 0);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (abort_at != 0 && i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("reset_valid", int'(out_valid), 0);
                chk("reset_data", int'(out_residual), 0);
                exp_q.delete();
                m_bc = 0;
                m_ac = 0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            chk("valid_run", int'(out_valid), 1);
        end
        check_fall = 1'b1;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 16; i++)
            src_b[i] = (mode == 0) ? 20 : (mode == 1) ? 255 : (mode == 2) ? 0 : $urandom_range(255);
        for (int i = 0; i < 64; i++)
            src_a[i] = (mode == 0) ? i : (mode == 1) ? 0 : (mode == 2) ? 255 : $urandom_range(255);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_residual), 0);
        rst_n = 1'b1;

        fill(0);
        load_frame();
        send_vec(3'b000, 3'b000, 0);
        load_frame();
        send_vec(3'b010, 3'b110, 0);
        load_frame();
        send_vec(3'b110, 3'b010, 0);
        load_frame();
        send_vec(3'b100, 3'b011, 0);

        fill(1);
        load_frame();
        send_vec(3'(($urandom_range(7))), 3'(($urandom_range(7))), 0);
        fill(2);
        load_frame();
        send_vec(3'b001, 3'b111, 0);

        // 17 block pixels wrap onto b[0][0]; the dual-strobe area pixel is dropped.
        fill(3);
        for (int i = 0; i < 16; i++) push_block(src_b[i]);
        push_block(8'hA5);
        push_both(8'h3C);
        for (int i = 0; i < 64; i++) push_area(src_a[i]);
        send_vec(3'b000, 3'b000, 0);

        fill(3);
        load_frame();
        send_vec(3'b001, 3'b010, 5);
        fill(0);
        load_frame();
        send_vec(3'b000, 3'b000, 0);

        for (int k = 0; k < 6; k++) begin
            fill(3);
            load_frame();
            send_vec(3'($urandom_range(7)), 3'($urandom_range(7)), 0);
        end

        repeat (3) @(posedge clk);
        #1;
        fall_check();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
